// File: rtl/stream_sched_pkg.sv
// Shared types and constants for the streaming write burst scheduler.
// Holds the FSM state encoding, the AXI encodings used and the burst byte-size helper.
package stream_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    ADDR = 2'd2,
    DATA = 2'd3
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int         BEAT_BYTES     = 4;

  // Burst size in bytes, 33 bits wide so ring-end comparisons never wrap past 2^32.
  function automatic logic [32:0] burst_bytes(input logic [7:0] len);
    return ({25'd0, len} + 33'd1) * 33'(BEAT_BYTES);
  endfunction

endpackage

// File: rtl/stream_wr_burst_scheduler_if.sv
// AXI write-master channel bundle (AW, W, B) between the scheduler and the AXI port.
// The master modport is the scheduler side; the slave modport is the interconnect side.
interface stream_wr_burst_scheduler_if #(
  parameter int ID_WIDTH = 2
);

  logic [ID_WIDTH-1:0] MASTER_WR_ADDR_ID;
  logic [31:0]         MASTER_WR_ADDR;
  logic [7:0]          MASTER_WR_ADDR_LEN;
  logic [1:0]          MASTER_WR_ADDR_BURST;
  logic                MASTER_WR_ADDR_VALID;
  logic                MASTER_WR_ADDR_READY;

  logic [31:0]         MASTER_WR_DATA;
  logic [3:0]          MASTER_WR_DATA_STRB;
  logic                MASTER_WR_DATA_LAST;
  logic                MASTER_WR_DATA_VALID;
  logic                MASTER_WR_DATA_READY;

  logic [ID_WIDTH-1:0] MASTER_WR_BACK_ID;
  logic [1:0]          MASTER_WR_BACK_RESP;
  logic                MASTER_WR_BACK_VALID;
  logic                MASTER_WR_BACK_READY;

  modport master (
    output MASTER_WR_ADDR_ID, MASTER_WR_ADDR, MASTER_WR_ADDR_LEN, MASTER_WR_ADDR_BURST,
           MASTER_WR_ADDR_VALID,
    input  MASTER_WR_ADDR_READY,
    output MASTER_WR_DATA, MASTER_WR_DATA_STRB, MASTER_WR_DATA_LAST, MASTER_WR_DATA_VALID,
    input  MASTER_WR_DATA_READY,
    input  MASTER_WR_BACK_ID, MASTER_WR_BACK_RESP, MASTER_WR_BACK_VALID,
    output MASTER_WR_BACK_READY
  );

  modport slave (
    input  MASTER_WR_ADDR_ID, MASTER_WR_ADDR, MASTER_WR_ADDR_LEN, MASTER_WR_ADDR_BURST,
           MASTER_WR_ADDR_VALID,
    output MASTER_WR_ADDR_READY,
    input  MASTER_WR_DATA, MASTER_WR_DATA_STRB, MASTER_WR_DATA_LAST, MASTER_WR_DATA_VALID,
    output MASTER_WR_DATA_READY,
    output MASTER_WR_BACK_ID, MASTER_WR_BACK_RESP, MASTER_WR_BACK_VALID,
    input  MASTER_WR_BACK_READY
  );

endinterface

// File: rtl/stream_wr_burst_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches cyclically from last+1 for the first request.
// Returns a one-hot grant, its index and a flag telling whether anything was granted.
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          valid
);

  int            cand;
  logic [IW-1:0] cand_idx;

  always_comb begin
    grant    = '0;
    idx      = '0;
    valid    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int off = 1; off <= N; off++) begin
      cand     = (int'(last) + off) % N;
      cand_idx = IW'(cand);
      if (!valid && req[cand_idx]) begin
        valid           = 1'b1;
        idx             = cand_idx;
        grant[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_wr_burst_scheduler.sv
// Round-robin scheduler sharing one AXI write master between SRC_NUM streaming sources,
// placing each burst inside the granted source's DDR ring window and generating W LAST.
module stream_wr_burst_scheduler
  import stream_sched_pkg::*;
#(
  parameter int SRC_NUM         = 2,
  parameter int ID_WIDTH        = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                     clk,
  input  logic                     rst,

  input  logic [SRC_NUM-1:0]       src_enable,
  input  logic [SRC_NUM-1:0]       src_addr_reset,
  input  logic [SRC_NUM-1:0][31:0] start_addr,
  input  logic [SRC_NUM-1:0][31:0] end_addr,

  input  logic [SRC_NUM-1:0]       src_burst_valid,
  output logic [SRC_NUM-1:0]       src_burst_ready,
  input  logic [SRC_NUM-1:0][7:0]  src_burst_len,

  input  logic [SRC_NUM-1:0]       src_data_valid,
  output logic [SRC_NUM-1:0]       src_data_ready,
  input  logic [SRC_NUM-1:0][31:0] src_data,
  input  logic [SRC_NUM-1:0]       src_data_last,

  stream_wr_burst_scheduler_if.master m_axi,

  output logic [SRC_NUM-1:0]       wrap_pulse,
  output logic                     resp_err,
  output logic                     last_err
);

  localparam int         IW      = (SRC_NUM > 1) ? $clog2(SRC_NUM) : 1;
  localparam logic [3:0] OUT_MAX = 4'(MAX_OUTSTANDING);

  state_e                     state_q, state_d;
  logic [IW-1:0]              rr_q, rr_d;
  logic [IW-1:0]              gnt_q, gnt_d;
  logic [7:0]                 len_q, len_d;
  logic [31:0]                addr_q, addr_d;
  logic [7:0]                 beat_q, beat_d;
  logic [3:0]                 outst_q, outst_d;
  logic [SRC_NUM-1:0][31:0]   ptr_q, ptr_d;
  logic [SRC_NUM-1:0]         en_q;
  logic                       resp_err_q, resp_err_d;
  logic                       last_err_q, last_err_d;
  logic                       bready_q;

  logic [SRC_NUM-1:0]         eligible;
  logic [SRC_NUM-1:0]         reload;
  logic [SRC_NUM-1:0]         arb_grant;
  logic [IW-1:0]              arb_idx;
  logic                       arb_valid;

  logic [31:0]                cur_ptr;
  logic [32:0]                bytes;
  logic [32:0]                end_chk;
  logic                       do_wrap;
  logic [31:0]                issue_addr;

  logic                       w_last;
  logic                       aw_hs;
  logic                       b_hs;
  logic                       unused_bid;

  assign eligible   = src_enable & src_burst_valid;
  assign reload     = src_addr_reset | (src_enable & ~en_q);
  assign w_last     = (beat_q == len_q);
  assign b_hs       = m_axi.MASTER_WR_BACK_VALID & bready_q;
  assign unused_bid = ^m_axi.MASTER_WR_BACK_ID;

  rr_arbiter #(.N(SRC_NUM)) u_arb (
    .req   (eligible),
    .last  (rr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // Ring placement: a burst that would run past end_addr restarts at start_addr.
  always_comb begin
    cur_ptr    = ptr_q[arb_idx];
    bytes      = burst_bytes(src_burst_len[arb_idx]);
    end_chk    = {1'b0, cur_ptr} + bytes - 33'd1;
    do_wrap    = end_chk > {1'b0, end_addr[arb_idx]};
    issue_addr = do_wrap ? start_addr[arb_idx] : cur_ptr;
  end

  always_comb begin
    state_d         = state_q;
    rr_d            = rr_q;
    gnt_d           = gnt_q;
    len_d           = len_q;
    addr_d          = addr_q;
    beat_d          = beat_q;
    ptr_d           = ptr_q;
    resp_err_d      = resp_err_q;
    last_err_d      = last_err_q;
    outst_d         = outst_q;
    src_burst_ready = '0;
    src_data_ready  = '0;
    wrap_pulse      = '0;
    aw_hs           = 1'b0;

    case (state_q)
      IDLE: begin
        if ((|eligible) && (outst_q < OUT_MAX)) begin
          state_d = ARB;
        end
      end
      ARB: begin
        if (arb_valid) begin
          src_burst_ready = arb_grant;
          gnt_d           = arb_idx;
          len_d           = src_burst_len[arb_idx];
          addr_d          = issue_addr;
          rr_d            = arb_idx;
          ptr_d[arb_idx]  = issue_addr + bytes[31:0];
          if (do_wrap) begin
            wrap_pulse = arb_grant;
          end
          state_d = ADDR;
        end else begin
          state_d = IDLE;
        end
      end
      ADDR: begin
        if (m_axi.MASTER_WR_ADDR_READY) begin
          aw_hs   = 1'b1;
          beat_d  = 8'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        src_data_ready[gnt_q] = m_axi.MASTER_WR_DATA_READY;
        if (src_data_valid[gnt_q] && m_axi.MASTER_WR_DATA_READY) begin
          if (src_data_last[gnt_q] != w_last) begin
            last_err_d = 1'b1;
          end
          if (w_last) begin
            beat_d  = 8'd0;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A reload overrides the ARB pointer update; the granted burst keeps its old address.
    for (int i = 0; i < SRC_NUM; i++) begin
      if (reload[i]) begin
        ptr_d[i] = start_addr[i];
      end
    end

    if (b_hs && (m_axi.MASTER_WR_BACK_RESP != AXI_RESP_OKAY)) begin
      resp_err_d = 1'b1;
    end

    case ({aw_hs, b_hs})
      2'b10:   outst_d = outst_q + 4'd1;
      2'b01:   outst_d = (outst_q != 4'd0) ? outst_q - 4'd1 : outst_q;
      default: outst_d = outst_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_q       <= IW'(SRC_NUM - 1);
      gnt_q      <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      beat_q     <= '0;
      outst_q    <= '0;
      ptr_q      <= start_addr;
      en_q       <= '0;
      resp_err_q <= 1'b0;
      last_err_q <= 1'b0;
      bready_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      gnt_q      <= gnt_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      beat_q     <= beat_d;
      outst_q    <= outst_d;
      ptr_q      <= ptr_d;
      en_q       <= src_enable;
      resp_err_q <= resp_err_d;
      last_err_q <= last_err_d;
      bready_q   <= 1'b1;
    end
  end

  assign m_axi.MASTER_WR_ADDR_VALID = (state_q == ADDR);
  assign m_axi.MASTER_WR_ADDR       = addr_q;
  assign m_axi.MASTER_WR_ADDR_LEN   = len_q;
  assign m_axi.MASTER_WR_ADDR_BURST = AXI_BURST_INCR;
  assign m_axi.MASTER_WR_ADDR_ID    = ID_WIDTH'(gnt_q);

  assign m_axi.MASTER_WR_DATA       = src_data[gnt_q];
  assign m_axi.MASTER_WR_DATA_STRB  = 4'hF;
  assign m_axi.MASTER_WR_DATA_LAST  = w_last;
  assign m_axi.MASTER_WR_DATA_VALID = (state_q == DATA) && src_data_valid[gnt_q];

  assign m_axi.MASTER_WR_BACK_READY = bready_q;

  assign resp_err = resp_err_q;
  assign last_err = last_err_q;

endmodule

// File: tb/tb_stream_wr_burst_scheduler.sv
// Scoreboard bench: stimulus pushes expected grants, AW and W beats; a monitor pops and compares.
module tb_stream_wr_burst_scheduler;
  import stream_sched_pkg::*;

  localparam int SRC_NUM = 2;
  localparam int ID_W    = 2;
  localparam int MAX_OUT = 4;

  typedef struct { int src; bit wrap; } grant_t;
  typedef struct { logic [31:0] addr; int id; int len; } aw_t;
  typedef struct { logic [31:0] data; bit last; } w_t;

  logic clk = 1'b0;
  logic rst;
  logic [SRC_NUM-1:0]       src_enable, src_addr_reset;
  logic [SRC_NUM-1:0][31:0] start_addr, end_addr;
  logic [SRC_NUM-1:0]       src_burst_valid, src_burst_ready;
  logic [SRC_NUM-1:0][7:0]  src_burst_len;
  logic [SRC_NUM-1:0]       src_data_valid, src_data_ready;
  logic [SRC_NUM-1:0][31:0] src_data;
  logic [SRC_NUM-1:0]       src_data_last;
  logic [SRC_NUM-1:0]       wrap_pulse;
  logic                     resp_err, last_err;

  stream_wr_burst_scheduler_if #(.ID_WIDTH(ID_W)) axi ();

  stream_wr_burst_scheduler #(
    .SRC_NUM(SRC_NUM), .ID_WIDTH(ID_W), .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clk(clk), .rst(rst),
    .src_enable(src_enable), .src_addr_reset(src_addr_reset),
    .start_addr(start_addr), .end_addr(end_addr),
    .src_burst_valid(src_burst_valid), .src_burst_ready(src_burst_ready),
    .src_burst_len(src_burst_len),
    .src_data_valid(src_data_valid), .src_data_ready(src_data_ready),
    .src_data(src_data), .src_data_last(src_data_last),
    .m_axi(axi),
    .wrap_pulse(wrap_pulse), .resp_err(resp_err), .last_err(last_err)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  int     aw_seen = 0;
  int     w_seen = 0;
  bit     abort = 1'b0;
  grant_t exp_gnt[$];
  aw_t    exp_aw[$];
  w_t     exp_w[$];

  function automatic logic [31:0] beat_data(int s, int tag, int beat);
    return 32'(((s + 1) << 24) | (tag << 8) | beat);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  task automatic expectBurst(input int s, input logic [31:0] addr, input int len, input int tag, input bit wrap);
    exp_gnt.push_back('{src: s, wrap: wrap});
    exp_aw.push_back('{addr: addr, id: s, len: len});
    for (int b = 0; b <= len; b++) exp_w.push_back('{data: beat_data(s, tag, b), last: (b == len)});
  endtask

  // Source model: offer a burst, wait for the grant, then stream its beats.
  task automatic applyStimulus(input int s, input int len, input int tag, input bit early);
    int beat = 0;
    int waitc = 0;
    bit hs;
    bit granted = 1'b0;
    src_burst_valid[s] = 1'b1;
    src_burst_len[s]   = 8'(len);
    forever begin
      @(negedge clk);
      if (src_burst_ready[s]) begin granted = 1'b1; break; end
      if (abort) break;
      waitc++;
      if (waitc > 3000) begin
        errors++;
        $display("[TB] FAIL grant_timeout src=%0d actual=none required=grant", s);
        break;
      end
    end
    @(posedge clk); #1;
    src_burst_valid[s] = 1'b0;
    waitc = 0;
    while (granted && beat <= len && !abort) begin
      src_data_valid[s] = 1'b1;
      src_data[s]       = beat_data(s, tag, beat);
      src_data_last[s]  = early ? (beat == len - 1) : (beat == len);
      @(negedge clk);
      hs = src_data_ready[s];
      @(posedge clk); #1;
      if (hs) beat++;
      else if (++waitc > 3000) begin
        errors++;
        $display("[TB] FAIL beat_timeout src=%0d actual=%0d required=%0d", s, beat, len + 1);
        break;
      end
    end
    src_data_valid[s] = 1'b0;
    src_data_last[s]  = 1'b0;
  endtask

  task automatic sendB(input logic [1:0] resp);
    @(posedge clk); #1;
    axi.MASTER_WR_BACK_VALID = 1'b1;
    axi.MASTER_WR_BACK_RESP  = resp;
    @(posedge clk); #1;
    axi.MASTER_WR_BACK_VALID = 1'b0;
    axi.MASTER_WR_BACK_RESP  = AXI_RESP_OKAY;
  endtask

  task automatic drainB(input int n);
    for (int i = 0; i < n; i++) sendB(AXI_RESP_OKAY);
  endtask

  task automatic waitAw(input int n);
    int c = 0;
    while (aw_seen < n && c < 2000) begin @(posedge clk); c++; end
    if (aw_seen < n) begin
      errors++;
      $display("[TB] FAIL aw_wait actual=%0d required=%0d", aw_seen, n);
    end
  endtask

  task automatic waitW(input int n);
    int c = 0;
    while (w_seen < n && c < 2000) begin @(posedge clk); c++; end
    if (w_seen < n) begin
      errors++;
      $display("[TB] FAIL w_wait actual=%0d required=%0d", w_seen, n);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_awvalid"}, axi.MASTER_WR_ADDR_VALID, 0);
    checkOutput({tag, "_wvalid"}, axi.MASTER_WR_DATA_VALID, 0);
    checkOutput({tag, "_burst_ready"}, src_burst_ready, 0);
    checkOutput({tag, "_data_ready"}, src_data_ready, 0);
    checkOutput({tag, "_bready"}, axi.MASTER_WR_BACK_READY, 1);
    checkOutput({tag, "_wrap"}, wrap_pulse, 0);
    checkOutput({tag, "_resp_err"}, resp_err, 0);
    checkOutput({tag, "_last_err"}, last_err, 0);
  endtask

  // Monitor: every grant, AW handshake and W handshake is compared against the scoreboard.
  initial begin
    grant_t g;
    aw_t    a;
    w_t     w;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (src_burst_ready != '0) begin
          if (exp_gnt.size() == 0) begin
            errors++;
            $display("[TB] FAIL grant_unexpected actual=%b required=none", src_burst_ready);
          end else begin
            g = exp_gnt.pop_front();
            checkOutput("grant_src", src_burst_ready, 64'(1) << g.src);
            checkOutput("wrap_pulse", wrap_pulse, g.wrap ? (64'(1) << g.src) : 64'd0);
          end
        end else if (wrap_pulse != '0) begin
          errors++;
          $display("[TB] FAIL wrap_spurious actual=%b required=0", wrap_pulse);
        end
        if (axi.MASTER_WR_ADDR_VALID && axi.MASTER_WR_ADDR_READY) begin
          aw_seen++;
          if (exp_aw.size() == 0) begin
            errors++;
            $display("[TB] FAIL aw_unexpected actual=%0h required=none", axi.MASTER_WR_ADDR);
          end else begin
            a = exp_aw.pop_front();
            checkOutput("aw_addr", axi.MASTER_WR_ADDR, a.addr);
            checkOutput("aw_id", axi.MASTER_WR_ADDR_ID, a.id);
            checkOutput("aw_len", axi.MASTER_WR_ADDR_LEN, a.len);
            checkOutput("aw_burst", axi.MASTER_WR_ADDR_BURST, AXI_BURST_INCR);
          end
        end
        if (axi.MASTER_WR_DATA_VALID && axi.MASTER_WR_DATA_READY) begin
          w_seen++;
          if (exp_w.size() == 0) begin
            errors++;
            $display("[TB] FAIL w_unexpected actual=%0h required=none", axi.MASTER_WR_DATA);
          end else begin
            w = exp_w.pop_front();
            checkOutput("w_data", axi.MASTER_WR_DATA, w.data);
            checkOutput("w_last", axi.MASTER_WR_DATA_LAST, w.last);
            checkOutput("w_strb", axi.MASTER_WR_DATA_STRB, 4'hF);
          end
        end
      end
    end
  end

  initial begin
    int base;
    rst = 1'b1;
    src_enable = '0; src_addr_reset = '0;
    start_addr[0] = 32'h1000; end_addr[0] = 32'h1FFF;
    start_addr[1] = 32'h2000; end_addr[1] = 32'h2FFF;
    src_burst_valid = '0; src_burst_len = '0;
    src_data_valid = '0; src_data = '0; src_data_last = '0;
    axi.MASTER_WR_ADDR_READY = 1'b1;
    axi.MASTER_WR_DATA_READY = 1'b1;
    axi.MASTER_WR_BACK_VALID = 1'b0;
    axi.MASTER_WR_BACK_ID    = '0;
    axi.MASTER_WR_BACK_RESP  = AXI_RESP_OKAY;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); @(negedge clk);
    checkResetState("por");

    $display("[TB] single source, four len=15 bursts");
    src_enable[0] = 1'b1;
    repeat (2) @(posedge clk); #1;
    for (int k = 0; k < 4; k++) expectBurst(0, 32'h1000 + 32'(k * 64), 15, k, 1'b0);
    fork
      for (int k = 0; k < 4; k++) applyStimulus(0, 15, k, 1'b0);
      begin
        axi.MASTER_WR_ADDR_READY = 1'b0;
        repeat (5) @(posedge clk);
        #1 axi.MASTER_WR_ADDR_READY = 1'b1;
      end
    join
    drainB(4);

    // ptr=0x1100 wraps; then 0x1040, 0x1080 (exact fit to 0x10BF), 0x10C0 wraps again.
    $display("[TB] ring wrap with end=0x10BF");
    end_addr[0] = 32'h10BF;
    expectBurst(0, 32'h1000, 15, 10, 1'b1);
    expectBurst(0, 32'h1040, 15, 11, 1'b0);
    expectBurst(0, 32'h1080, 15, 12, 1'b0);
    expectBurst(0, 32'h1000, 15, 13, 1'b1);
    for (int k = 0; k < 4; k++) applyStimulus(0, 15, 10 + k, 1'b0);
    drainB(4);

    // Last grant was source 0, so source 1 wins first and grants alternate.
    $display("[TB] two sources alternating, len=3");
    src_enable[1] = 1'b1;
    repeat (2) @(posedge clk); #1;
    expectBurst(1, 32'h2000, 3, 20, 1'b0);
    expectBurst(0, 32'h1040, 3, 21, 1'b0);
    expectBurst(1, 32'h2010, 3, 22, 1'b0);
    expectBurst(0, 32'h1050, 3, 23, 1'b0);
    fork
      begin applyStimulus(0, 3, 21, 1'b0); applyStimulus(0, 3, 23, 1'b0); end
      begin applyStimulus(1, 3, 20, 1'b0); applyStimulus(1, 3, 22, 1'b0); end
    join
    drainB(4);

    $display("[TB] outstanding limit and error response");
    @(negedge clk);
    checkOutput("last_err_clean", last_err, 0);
    checkOutput("resp_err_clean", resp_err, 0);
    #1;
    base = aw_seen;
    for (int k = 0; k < 5; k++) expectBurst(0, 32'h1060 + 32'(k * 4), 0, 30 + k, 1'b0);
    fork
      for (int k = 0; k < 5; k++) applyStimulus(0, 0, 30 + k, 1'b0);
      begin
        waitAw(base + 4);
        repeat (30) @(posedge clk);
        checkOutput("aw_stall_count", aw_seen - base, 4);
        sendB(2'b10);
        waitAw(base + 5);
        checkOutput("aw_after_b", aw_seen - base, 5);
      end
    join
    @(negedge clk);
    checkOutput("resp_err_set", resp_err, 1);
    drainB(4);
    @(negedge clk);
    checkOutput("resp_err_sticky", resp_err, 1);
    #1;

    $display("[TB] W ready toggling with early source last, len=7");
    expectBurst(0, 32'h1074, 7, 40, 1'b0);
    fork
      applyStimulus(0, 7, 40, 1'b1);
      begin
        repeat (24) begin @(posedge clk); #1 axi.MASTER_WR_DATA_READY = ~axi.MASTER_WR_DATA_READY; end
        axi.MASTER_WR_DATA_READY = 1'b1;
      end
    join
    @(negedge clk);
    checkOutput("last_err_set", last_err, 1);
    #1;
    drainB(1);

    $display("[TB] pointer reload, then reset during DATA");
    @(posedge clk); #1 src_addr_reset[0] = 1'b1;
    @(posedge clk); #1 src_addr_reset[0] = 1'b0;
    expectBurst(0, 32'h1000, 15, 50, 1'b0);
    applyStimulus(0, 15, 50, 1'b0);
    drainB(1);
    expectBurst(0, 32'h1040, 15, 51, 1'b0);
    base = w_seen;
    fork
      applyStimulus(0, 15, 51, 1'b0);
      begin
        waitW(base + 3);
        @(posedge clk); #1;
        abort = 1'b1;
        rst   = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
      end
    join
    abort = 1'b0;
    exp_w.delete();
    exp_aw.delete();
    exp_gnt.delete();
    @(posedge clk); @(negedge clk);
    checkResetState("mid_rst");
    #1;
    // Pointers reload to start and source 0 wins first after reset.
    expectBurst(0, 32'h1000, 0, 60, 1'b0);
    expectBurst(1, 32'h2000, 0, 61, 1'b0);
    fork
      applyStimulus(0, 0, 60, 1'b0);
      applyStimulus(1, 0, 61, 1'b0);
    join
    drainB(2);

    repeat (5) @(posedge clk);
    checkOutput("exp_grant_left", exp_gnt.size(), 0);
    checkOutput("exp_aw_left", exp_aw.size(), 0);
    checkOutput("exp_w_left", exp_w.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
